// File: rtl/led_sequencer_if.sv
// Configuration handshake between the LED-bar controller and the sequencer.
// The master offers a configuration; the slave accepts it when its pending slot is free.
interface led_sequencer_if #(
  parameter int N_LEDS     = 8,
  parameter int PRESCALE_W = 16
);
  localparam int PW = $clog2(N_LEDS);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0]            cfg_mode;
  logic                  cfg_dir;
  logic [PRESCALE_W-1:0] cfg_period;
  logic [PW-1:0]         cfg_step;

  modport master (
    output cfg_valid, cfg_mode, cfg_dir, cfg_period, cfg_step,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_dir, cfg_period, cfg_step,
    output cfg_ready
  );
endinterface

// File: rtl/led_sequencer.sv
// LED-bar position sequencer: prescaled step tick moving a modulo position counter
// in wrap, bounce or one-shot sweep patterns, with a one-deep pending configuration.
module led_sequencer #(
  parameter  int N_LEDS     = 8,
  parameter  int PRESCALE_W = 16,
  localparam int PW         = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  led_sequencer_if.slave    cfg,
  output logic [PW-1:0]     pos,
  output logic [N_LEDS-1:0] leds,
  output logic              dir,
  output logic              busy,
  output logic              done
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0]  MODE_STOP   = 2'b00;
  localparam logic [1:0]  MODE_WRAP   = 2'b01;
  localparam logic [1:0]  MODE_BOUNCE = 2'b10;
  localparam logic [1:0]  MODE_SWEEP  = 2'b11;
  localparam logic [PW:0]   NL_X      = (PW+1)'(N_LEDS);
  localparam logic [PW:0]   LAST_X    = (PW+1)'(N_LEDS - 1);
  localparam logic [PW:0]   TWO_LAST  = (PW+1)'(2 * (N_LEDS - 1));
  localparam logic [PW-1:0] LAST      = PW'(N_LEDS - 1);

  state_t                state_r;
  logic                  pv_r;
  logic [1:0]            pend_mode_r;
  logic                  pend_dir_r;
  logic [PRESCALE_W-1:0] pend_period_r;
  logic [PW-1:0]         pend_step_r;
  logic [1:0]            mode_r;
  logic [PRESCALE_W-1:0] period_r;
  logic [PW-1:0]         step_r;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PW-1:0]         pos_r;
  logic                  dir_r;
  logic                  busy_r;
  logic                  done_r;

  logic [PW-1:0] cap_step_s;
  logic          tick_s;
  logic          apply_s;
  logic [PW:0]   posx_s;
  logic [PW:0]   stepx_s;
  logic [PW:0]   sum_s;
  logic [PW:0]   wrap_x_s;
  logic [PW:0]   bnc_x_s;
  logic          wrap_hit_s;
  logic          bnc_flip_s;
  logic [PW-1:0] nxt_pos_s;
  logic          nxt_flip_s;
  logic          sweep_end_s;

  assign tick_s  = (state_r == RUN) && (presc_r == period_r);
  assign apply_s = pv_r && ((state_r == IDLE) || tick_s);

  // Saturate the offered step so the move arithmetic never sees a step of N_LEDS or more.
  always_comb begin
    cap_step_s = cfg.cfg_step;
    if ({1'b0, cfg.cfg_step} > LAST_X) begin
      cap_step_s = LAST;
    end else begin
      cap_step_s = cfg.cfg_step;
    end
  end

  // Candidate next position for each pattern; sums are one bit wider than pos.
  always_comb begin
    posx_s      = {1'b0, pos_r};
    stepx_s     = {1'b0, step_r};
    sum_s       = posx_s + stepx_s;
    wrap_x_s    = posx_s;
    bnc_x_s     = posx_s;
    wrap_hit_s  = 1'b0;
    bnc_flip_s  = 1'b0;
    nxt_pos_s   = pos_r;
    nxt_flip_s  = 1'b0;
    sweep_end_s = 1'b0;
    if (!dir_r) begin
      wrap_hit_s = (sum_s >= NL_X);
      if (wrap_hit_s) begin
        wrap_x_s = sum_s - NL_X;
      end else begin
        wrap_x_s = sum_s;
      end
      if (sum_s > LAST_X) begin
        bnc_x_s    = TWO_LAST - sum_s;
        bnc_flip_s = 1'b1;
      end else begin
        bnc_x_s    = sum_s;
        bnc_flip_s = 1'b0;
      end
    end else begin
      wrap_hit_s = (posx_s < stepx_s);
      if (wrap_hit_s) begin
        wrap_x_s   = NL_X + posx_s - stepx_s;
        bnc_x_s    = stepx_s - posx_s;
        bnc_flip_s = 1'b1;
      end else begin
        wrap_x_s   = posx_s - stepx_s;
        bnc_x_s    = posx_s - stepx_s;
        bnc_flip_s = 1'b0;
      end
    end
    case (mode_r)
      MODE_WRAP: nxt_pos_s = wrap_x_s[PW-1:0];
      MODE_BOUNCE: begin
        nxt_pos_s  = bnc_x_s[PW-1:0];
        nxt_flip_s = bnc_flip_s;
      end
      MODE_SWEEP: begin
        if (wrap_hit_s) begin
          sweep_end_s = 1'b1;
        end else begin
          nxt_pos_s = wrap_x_s[PW-1:0];
        end
      end
      default: nxt_pos_s = pos_r;
    endcase
  end

  // Sequencer FSM: capture, apply pending (overrides the move), prescale and move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pv_r          <= 1'b0;
      pend_mode_r   <= MODE_STOP;
      pend_dir_r    <= 1'b0;
      pend_period_r <= {PRESCALE_W{1'b0}};
      pend_step_r   <= {PW{1'b0}};
      mode_r        <= MODE_STOP;
      period_r      <= {PRESCALE_W{1'b0}};
      step_r        <= {PW{1'b0}};
      presc_r       <= {PRESCALE_W{1'b0}};
      pos_r         <= {PW{1'b0}};
      dir_r         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (apply_s) begin
        pv_r     <= 1'b0;
        presc_r  <= {PRESCALE_W{1'b0}};
        mode_r   <= pend_mode_r;
        period_r <= pend_period_r;
        step_r   <= pend_step_r;
        if (pend_mode_r == MODE_STOP) begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end else begin
          state_r <= RUN;
          busy_r  <= 1'b1;
          dir_r   <= pend_dir_r;
          pos_r   <= pend_dir_r ? LAST : {PW{1'b0}};
        end
      end else if (tick_s) begin
        presc_r <= {PRESCALE_W{1'b0}};
        if (sweep_end_s) begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end else begin
          pos_r <= nxt_pos_s;
          dir_r <= dir_r ^ nxt_flip_s;
        end
      end else if (state_r == RUN) begin
        presc_r <= presc_r + PRESCALE_W'(1);
      end else begin
        presc_r <= {PRESCALE_W{1'b0}};
      end
      // Capture needs an empty slot, so it never coincides with an apply.
      if (cfg.cfg_valid && !pv_r) begin
        pend_mode_r   <= cfg.cfg_mode;
        pend_dir_r    <= cfg.cfg_dir;
        pend_period_r <= cfg.cfg_period;
        pend_step_r   <= cap_step_s;
        pv_r          <= 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = !pv_r;
  assign pos           = pos_r;
  assign dir           = dir_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign leds          = busy_r ? ({{(N_LEDS-1){1'b0}}, 1'b1} << pos_r) : {N_LEDS{1'b0}};
endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed sequences with literal expectations plus a long
// randomized run compared every cycle against a behavioural model of the sequencer.
module tb_led_sequencer;
  localparam int N   = 8;
  localparam int PW  = 3;
  localparam int PSW = 16;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic [PW-1:0] pos;
  logic [N-1:0]  leds;
  logic          dir, busy, done;

  led_sequencer_if #(.N_LEDS(N), .PRESCALE_W(PSW)) cfg_if ();

  led_sequencer #(.N_LEDS(N), .PRESCALE_W(PSW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg(cfg_if.slave),
    .pos(pos), .leds(leds), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  typedef struct packed {
    int pos; int dir; int run; int done; int pv; int cnt;
    int pmode; int pdir; int pper; int pstep;
    int amode; int aper; int astep;
  } mstate_t;

  mstate_t m;

  // Next model state from the sequencing rules, using plain signed integer arithmetic.
  function automatic mstate_t model_next(mstate_t s, bit v, int mode, int d, int per, int st);
    mstate_t n = s;
    int p;
    n.done = 0;
    if (s.pv != 0 && (s.run == 0 || s.cnt == s.aper)) begin
      n.pv = 0; n.cnt = 0;
      n.amode = s.pmode; n.aper = s.pper;
      n.astep = (s.pstep > N - 1) ? N - 1 : s.pstep;
      if (s.pmode == 0) n.run = 0;
      else begin
        n.run = 1; n.dir = s.pdir; n.pos = (s.pdir != 0) ? N - 1 : 0;
      end
    end else if (s.run != 0) begin
      if (s.cnt == s.aper) begin
        n.cnt = 0;
        p = (s.dir != 0) ? s.pos - s.astep : s.pos + s.astep;
        case (s.amode)
          1: n.pos = (p + N) % N;
          2: begin
            if (p > N - 1) begin n.pos = 2 * (N - 1) - p; n.dir = 1; end
            else if (p < 0) begin n.pos = -p; n.dir = 0; end
            else n.pos = p;
          end
          3: begin
            if (p < 0 || p > N - 1) begin n.run = 0; n.done = 1; end
            else n.pos = p;
          end
          default: n.pos = s.pos;
        endcase
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    if (v && s.pv == 0) begin
      n.pv = 1; n.pmode = mode; n.pdir = d; n.pper = per; n.pstep = st;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else m <= model_next(m, cfg_if.cfg_valid, int'(cfg_if.cfg_mode), int'(cfg_if.cfg_dir),
                         int'(cfg_if.cfg_period), int'(cfg_if.cfg_step));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pos",   32'(pos),             32'(m.pos));
      check("model_dir",   32'(dir),             32'(m.dir));
      check("model_busy",  32'(busy),            32'(m.run));
      check("model_done",  32'(done),            32'(m.done));
      check("model_ready", 32'(cfg_if.cfg_ready), (m.pv == 0) ? 32'd1 : 32'd0);
      check("model_leds",  32'(leds),            (m.run != 0) ? (32'd1 << m.pos) : 32'd0);
    end
  end

  task automatic send_cfg(input int mode, input int d, input int per, input int st);
    int w = 0;
    while (!cfg_if.cfg_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_if.cfg_ready) check("cfg_ready_wait", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_dir    = 1'(d);
    cfg_if.cfg_period = 16'(per);
    cfg_if.cfg_step   = 3'(st);
    cfg_if.cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int wu[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 0};
  int wd[9] = '{7, 4, 1, 6, 3, 0, 5, 2, 7};
  int bu[9] = '{0, 3, 6, 5, 2, 1, 4, 7, 4};
  int bd[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
  int su[4] = '{0, 2, 4, 6};

  initial begin
    bit last_rdy;
    int w;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = 2'b00; cfg_if.cfg_dir = 1'b0;
    cfg_if.cfg_period = 16'd0; cfg_if.cfg_step = 3'd0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Async reset in the middle of a WRAP-down run.
    send_cfg(1, 1, 0, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_move_busy", 32'(busy), 32'd0);
    check("rst_no_move_pos", 32'(pos), 32'd0);

    do_reset();
    send_cfg(1, 0, 0, 3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("wrap_up_pos", 32'(pos), 32'(wu[i]));
      check("wrap_up_leds", 32'(leds), 32'd1 << wu[i]);
    end

    do_reset();
    send_cfg(1, 1, 0, 3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("wrap_down_pos", 32'(pos), 32'(wd[i]));
    end

    do_reset();
    send_cfg(2, 0, 1, 3);
    @(negedge clk);
    check("bounce_pos", 32'(pos), 32'(bu[0]));
    for (int i = 1; i < 9; i++) begin
      repeat (2) @(negedge clk);
      check("bounce_pos", 32'(pos), 32'(bu[i]));
      check("bounce_dir", 32'(dir), 32'(bd[i]));
    end

    do_reset();
    send_cfg(3, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sweep_pos", 32'(pos), 32'(su[i]));
    end
    @(negedge clk);
    check("sweep_end_pos", 32'(pos), 32'd6);
    check("sweep_end_busy", 32'(busy), 32'd0);
    check("sweep_end_leds", 32'(leds), 32'd0);
    check("sweep_end_done", 32'(done), 32'd1);
    @(negedge clk);
    check("sweep_done_fall", 32'(done), 32'd0);

    // New config captured mid-period while running; a second one must wait for the tick.
    do_reset();
    send_cfg(1, 0, 3, 1);
    repeat (2) @(negedge clk);
    send_cfg(2, 1, 3, 2);
    check("run_cfg_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    cfg_if.cfg_mode = 2'b01; cfg_if.cfg_dir = 1'b0; cfg_if.cfg_period = 16'd0;
    cfg_if.cfg_step = 3'd2; cfg_if.cfg_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!cfg_if.cfg_ready && w < 20);
    check("run_hold_cycles", 32'(w), 32'd2);
    check("run_apply_pos", 32'(pos), 32'd7);
    check("run_apply_dir", 32'(dir), 32'd1);
    check("run_apply_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;

    // Randomized traffic, with occasional asynchronous resets.
    do_reset();
    last_rdy = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (cfg_if.cfg_valid && last_rdy) cfg_if.cfg_valid = 1'b0;
      if (!cfg_if.cfg_valid && $urandom_range(0, 5) == 0) begin
        cfg_if.cfg_mode   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        cfg_if.cfg_dir    = 1'($urandom_range(0, 1));
        cfg_if.cfg_period = 16'($urandom_range(0, 3));
        cfg_if.cfg_step   = 3'($urandom_range(0, 7));
        cfg_if.cfg_valid  = 1'b1;
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      last_rdy = cfg_if.cfg_ready;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
